// File: rtl/branch_predictor.sv
//------------------------------------------------------------------------------
// branch_predictor : 2-bit BHT + direct-mapped BTB for the IF stage
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module branch_predictor #(
  parameter int XLEN        = `XLEN,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_if,
  output logic            btb_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  output logic [XLEN-1:0] predict_next_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target
);

  localparam int BIDX_W = $clog2(BHT_ENTRIES);
  localparam int TIDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = XLEN - TIDX_W - 2;

  logic [1:0]       bht        [BHT_ENTRIES];
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];

  logic [BIDX_W-1:0] bidx_if;
  logic [TIDX_W-1:0] tidx_if;
  logic [TAG_W-1:0]  tag_if;
  logic [BIDX_W-1:0] bidx_up;
  logic [TIDX_W-1:0] tidx_up;
  logic [TAG_W-1:0]  tag_up;
  logic [1:0]        ctr_up;
  logic              unused_pc_lsbs;

  assign bidx_if = pc_if[BIDX_W+1:2];
  assign tidx_if = pc_if[TIDX_W+1:2];
  assign tag_if  = pc_if[XLEN-1:TIDX_W+2];
  assign bidx_up = update_pc[BIDX_W+1:2];
  assign tidx_up = update_pc[TIDX_W+1:2];
  assign tag_up  = update_pc[XLEN-1:TIDX_W+2];
  assign ctr_up  = bht[bidx_up];

  // Instruction-alignment bits never participate in indexing or tagging.
  assign unused_pc_lsbs = ^{pc_if[1:0], update_pc[1:0]};

  always_comb begin
    btb_hit         = btb_valid[tidx_if] && (btb_tag[tidx_if] == tag_if);
    predict_taken   = btb_hit && bht[bidx_if][1];
    predict_target  = btb_hit ? btb_target[tidx_if] : '0;
    predict_next_pc = predict_taken ? predict_target : pc_if + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (update_valid) begin
      if (update_taken && ctr_up != 2'b11) begin
        bht[bidx_up] <= ctr_up + 2'b01;
      end else if (!update_taken && ctr_up != 2'b00) begin
        bht[bidx_up] <= ctr_up - 2'b01;
      end
      // Not-taken outcomes leave the BTB entry alone; the BHT alone steers direction.
      if (update_taken) begin
        btb_valid[tidx_up]  <= 1'b1;
        btb_tag[tidx_up]    <= tag_up;
        btb_target[tidx_up] <= update_target;
      end
    end
  end

endmodule

`default_nettype wire
